wb_master_arbiter: RTL and testbench

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

---
 rtl/wb_master_arbiter_pkg.sv | 12 +
 rtl/wb_master_arbiter_rr.sv | 29 ++
 rtl/wb_master_arbiter.sv | 161 ++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_arbiter_pkg.sv
// Shared Wishbone arbiter definitions: FSM state encoding and default timeout.
package wb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_master_arbiter_rr.sv
// Combinational round-robin picker: one-hot grant to the first requester
// at or after ptr_i, wrapping from NM-1 back to 0.
module arbiter_rr #(
    parameter int unsigned NM = 3,
    parameter int unsigned PW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [NM-1:0] grant_o
);

    logic [PW-1:0] idx;
    logic          found;

    // Scan upwards from ptr with wraparound; the first active request wins.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < NM; k++) begin
            idx = PW'((32'(ptr_i) + k) % NM);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between NM requesters,
// with a stall timeout that aborts the owner's cycle with an error pulse.
module wb_master_arbiter
    import wb_master_arbiter_pkg::*;
#(
    parameter int unsigned NM      = 3,
    parameter int unsigned DW      = 32,
    parameter int unsigned M_Aw    = 32,
    parameter int unsigned SELw    = 4,
    parameter int unsigned TAGw    = 3,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NM*SELw-1:0]   s_sel_i,
    input  logic [NM*DW-1:0]     s_dat_i,
    input  logic [NM*M_Aw-1:0]   s_addr_i,
    input  logic [NM*TAGw-1:0]   s_cti_i,
    input  logic [NM-1:0]        s_stb_i,
    input  logic [NM-1:0]        s_cyc_i,
    input  logic [NM-1:0]        s_we_i,
    output logic [DW-1:0]        s_dat_o,
    output logic [NM-1:0]        s_ack_o,
    output logic [NM-1:0]        s_err_o,
    output logic [SELw-1:0]      m_sel_o,
    output logic [DW-1:0]        m_dat_o,
    output logic [M_Aw-1:0]      m_addr_o,
    output logic [TAGw-1:0]      m_cti_o,
    output logic                 m_stb_o,
    output logic                 m_cyc_o,
    output logic                 m_we_o,
    input  logic [DW-1:0]        m_dat_i,
    input  logic                 m_ack_i,
    input  logic                 m_err_i,
    output logic [NM-1:0]        grant_o
);

    localparam int unsigned PW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    arb_state_e    state_q;
    logic [NM-1:0] grant_q;
    logic [PW-1:0] idx_q;
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          abort_pulse_q;

    logic [NM-1:0] rr_grant;
    logic [PW-1:0] rr_idx;
    logic [PW-1:0] ptr_adv;
    logic          busy;
    logic          own_cyc;
    logic          own_stb;
    logic          stall;

    arbiter_rr #(
        .NM (NM),
        .PW (PW)
    ) u_rr (
        .req_i   (s_cyc_i),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant)
    );

    // Binary index of the round-robin winner.
    always_comb begin
        rr_idx = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (rr_grant[i]) rr_idx = PW'(i);
        end
    end

    assign busy    = (state_q == BUSY);
    assign own_cyc = s_cyc_i[idx_q];
    assign own_stb = s_stb_i[idx_q];
    assign stall   = busy && own_stb && !m_ack_i && !m_err_i;
    assign ptr_adv = (idx_q == PW'(NM - 1)) ? '0 : idx_q + PW'(1);
    // Abort is decided on the count this stalled cycle would reach, so an ack
    // arriving in that same cycle clears the counter instead.
    assign cnt_d   = cnt_q + CW'(1);
    assign grant_o = grant_q;
    assign s_dat_o = m_dat_i;

    // Arbitration FSM: grant, ownership hold, timeout abort and pointer update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            idx_q         <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            abort_pulse_q <= 1'b0;
        end else begin
            abort_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (|s_cyc_i) begin
                        grant_q <= rr_grant;
                        idx_q   <= rr_idx;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!own_cyc) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        ptr_q   <= ptr_adv;
                        cnt_q   <= '0;
                    end else if (stall) begin
                        if (cnt_d == CW'(TIMEOUT)) begin
                            state_q       <= ABORT;
                            abort_pulse_q <= 1'b1;
                            cnt_q         <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                ABORT: begin
                    cnt_q <= '0;
                    if (!own_cyc) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        ptr_q   <= ptr_adv;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Master port mux from the owner while BUSY; per-requester ack/err routing.
    always_comb begin
        m_sel_o  = '0;
        m_dat_o  = '0;
        m_addr_o = '0;
        m_cti_o  = '0;
        m_stb_o  = 1'b0;
        m_cyc_o  = 1'b0;
        m_we_o   = 1'b0;
        if (busy) begin
            m_sel_o  = s_sel_i[idx_q*SELw +: SELw];
            m_dat_o  = s_dat_i[idx_q*DW +: DW];
            m_addr_o = s_addr_i[idx_q*M_Aw +: M_Aw];
            m_cti_o  = s_cti_i[idx_q*TAGw +: TAGw];
            m_stb_o  = own_stb;
            m_cyc_o  = own_cyc;
            m_we_o   = s_we_i[idx_q];
        end
        s_ack_o = (busy && m_ack_i) ? grant_q : '0;
        s_err_o = ((busy && m_err_i) || abort_pulse_q) ? grant_q : '0;
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter (NM=3, TIMEOUT=8): directed
// scenarios plus a randomized run against a behavioural arbitration model.
module tb_wb_master_arbiter;

    localparam int unsigned NM   = 3;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 32;
    localparam int unsigned SELW = 4;
    localparam int unsigned TAGW = 3;
    localparam int unsigned TO   = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NM*SELW-1:0]  s_sel_i;
    logic [NM*DW-1:0]    s_dat_i;
    logic [NM*AW-1:0]    s_addr_i;
    logic [NM*TAGW-1:0]  s_cti_i;
    logic [NM-1:0]       s_stb_i, s_cyc_i, s_we_i;
    logic [DW-1:0]       s_dat_o;
    logic [NM-1:0]       s_ack_o, s_err_o;
    logic [SELW-1:0]     m_sel_o;
    logic [DW-1:0]       m_dat_o;
    logic [AW-1:0]       m_addr_o;
    logic [TAGW-1:0]     m_cti_o;
    logic                m_stb_o, m_cyc_o, m_we_o;
    logic [DW-1:0]       m_dat_i;
    logic                m_ack_i, m_err_i;
    logic [NM-1:0]       grant_o;

    int checks = 0;
    int errors = 0;

    wb_master_arbiter #(
        .NM      (NM),
        .DW      (DW),
        .M_Aw    (AW),
        .SELw    (SELW),
        .TAGw    (TAGW),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s_sel_i  (s_sel_i),
        .s_dat_i  (s_dat_i),
        .s_addr_i (s_addr_i),
        .s_cti_i  (s_cti_i),
        .s_stb_i  (s_stb_i),
        .s_cyc_i  (s_cyc_i),
        .s_we_i   (s_we_i),
        .s_dat_o  (s_dat_o),
        .s_ack_o  (s_ack_o),
        .s_err_o  (s_err_o),
        .m_sel_o  (m_sel_o),
        .m_dat_o  (m_dat_o),
        .m_addr_o (m_addr_o),
        .m_cti_o  (m_cti_o),
        .m_stb_o  (m_stb_o),
        .m_cyc_o  (m_cyc_o),
        .m_we_o   (m_we_o),
        .m_dat_i  (m_dat_i),
        .m_ack_i  (m_ack_i),
        .m_err_i  (m_err_i),
        .grant_o  (grant_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        s_sel_i  = '0;
        s_dat_i  = '0;
        s_addr_i = '0;
        s_cti_i  = '0;
        s_stb_i  = '0;
        s_cyc_i  = '0;
        s_we_i   = '0;
        m_dat_i  = '0;
        m_ack_i  = 1'b0;
        m_err_i  = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic set_req(input int unsigned i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [TAGW-1:0] cti);
        s_we_i[i]                = we;
        s_addr_i[i*AW +: AW]     = a;
        s_dat_i[i*DW +: DW]      = d;
        s_cti_i[i*TAGW +: TAGW]  = cti;
        s_sel_i[i*SELW +: SELW]  = '1;
    endtask

    // Round-robin rule: first requester at or after p, wrapping.
    function automatic int pick(input logic [NM-1:0] req, input int unsigned p);
        for (int unsigned k = 0; k < NM; k++) begin
            if (req[(p + k) % NM]) return int'((p + k) % NM);
        end
        return 0;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        set_req(0, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 3'b010);
        s_cyc_i = '1; s_stb_i = '1; m_ack_i = 1'b1; m_err_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant_o); end
        checks++; if (m_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_m_cyc: got %b expected 0", m_cyc_o); end
        checks++; if (m_stb_o !== 1'b0) begin errors++; $display("FAIL reset_m_stb: got %b expected 0", m_stb_o); end
        checks++; if (m_addr_o !== '0) begin errors++; $display("FAIL reset_m_addr: got %h expected 0", m_addr_o); end
        checks++; if (s_ack_o !== 3'b000) begin errors++; $display("FAIL reset_s_ack: got %b expected 000", s_ack_o); end
        checks++; if (s_err_o !== 3'b000) begin errors++; $display("FAIL reset_s_err: got %b expected 000", s_err_o); end
    endtask

    task automatic test_round_robin();
        int unsigned exp_owner = 0;
        logic [NM-1:0] exp_g;
        apply_reset();
        for (int unsigned i = 0; i < NM; i++) set_req(i, 1'b0, 32'h100 * (i + 1), 32'h0, 3'b000);
        s_cyc_i = '1; s_stb_i = '1;
        settle();
        checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL rr_latency: got %b expected 000", grant_o); end
        for (int n = 0; n < 4; n++) begin
            tick();
            m_ack_i = 1'b1;
            settle();
            exp_g = '0; exp_g[exp_owner] = 1'b1;
            checks++; if (grant_o !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", n, grant_o, exp_g); end
            checks++; if (s_ack_o !== exp_g) begin errors++; $display("FAIL rr_ack%0d: got %b expected %b", n, s_ack_o, exp_g); end
            checks++; if (m_addr_o !== 32'h100 * (exp_owner + 1)) begin errors++; $display("FAIL rr_addr%0d: got %h expected %h", n, m_addr_o, 32'h100 * (exp_owner + 1)); end
            tick();
            m_ack_i = 1'b0; s_cyc_i[exp_owner] = 1'b0; s_stb_i[exp_owner] = 1'b0;
            settle();
            checks++; if (m_cyc_o !== 1'b0) begin errors++; $display("FAIL rr_release%0d: got %b expected 0", n, m_cyc_o); end
            tick();
            s_cyc_i = '1; s_stb_i = '1;
            settle();
            checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL rr_gap%0d: got %b expected 000", n, grant_o); end
            exp_owner = (exp_owner + 1) % NM;
        end
    endtask

    task automatic test_burst();
        int acks1 = 0;
        int acks0 = 0;
        int unsigned beat = 0;
        logic [NM-1:0] exp_ack;
        apply_reset();
        set_req(1, 1'b1, 32'h0000_2000, 32'h1111_0000, 3'b010);
        set_req(0, 1'b0, 32'h0000_0100, 32'h0, 3'b000);
        s_cyc_i = 3'b010; s_stb_i = 3'b010;
        tick();
        s_cyc_i = 3'b011; s_stb_i = 3'b011;
        for (int n = 0; n < 5; n++) begin
            m_ack_i = (n != 1);
            set_req(1, 1'b1, 32'h0000_2000 + 4 * beat, 32'h1111_0000 + beat, 3'b010);
            settle();
            exp_ack = m_ack_i ? 3'b010 : 3'b000;
            checks++; if (grant_o !== 3'b010) begin errors++; $display("FAIL burst_grant%0d: got %b expected 010", n, grant_o); end
            checks++; if (s_ack_o !== exp_ack) begin errors++; $display("FAIL burst_ack%0d: got %b expected %b", n, s_ack_o, exp_ack); end
            checks++; if (m_dat_o !== 32'h1111_0000 + beat) begin errors++; $display("FAIL burst_wdat%0d: got %h expected %h", n, m_dat_o, 32'h1111_0000 + beat); end
            checks++; if ({m_we_o, m_cti_o} !== 4'b1010) begin errors++; $display("FAIL burst_we_cti%0d: got %b expected 1010", n, {m_we_o, m_cti_o}); end
            if (s_ack_o[1]) acks1++;
            if (s_ack_o[0]) acks0++;
            if (m_ack_i) beat++;
            tick();
        end
        m_ack_i = 1'b0; s_cyc_i[1] = 1'b0; s_stb_i[1] = 1'b0;
        settle();
        checks++; if (grant_o !== 3'b010) begin errors++; $display("FAIL burst_hold: got %b expected 010", grant_o); end
        tick();
        checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL burst_idle: got %b expected 000", grant_o); end
        tick();
        checks++; if (grant_o !== 3'b001) begin errors++; $display("FAIL burst_next: got %b expected 001", grant_o); end
        checks++; if (acks1 !== 4) begin errors++; $display("FAIL burst_ack_count: got %0d expected 4", acks1); end
        checks++; if (acks0 !== 0) begin errors++; $display("FAIL burst_m0_acks: got %0d expected 0", acks0); end
    endtask

    task automatic test_timeout();
        apply_reset();
        set_req(2, 1'b0, 32'h0000_3000, 32'h0, 3'b000);
        s_cyc_i = 3'b100; s_stb_i = 3'b100;
        tick();
        for (int k = 0; k < int'(TO); k++) begin
            settle();
            checks++; if ({m_cyc_o, m_stb_o, s_err_o} !== 5'b11000) begin errors++; $display("FAIL to_wait%0d: got %b expected 11000", k, {m_cyc_o, m_stb_o, s_err_o}); end
            tick();
        end
        settle();
        checks++; if (s_err_o !== 3'b100) begin errors++; $display("FAIL to_err: got %b expected 100", s_err_o); end
        checks++; if ({m_cyc_o, m_stb_o} !== 2'b00) begin errors++; $display("FAIL to_mport: got %b expected 00", {m_cyc_o, m_stb_o}); end
        checks++; if (grant_o !== 3'b100) begin errors++; $display("FAIL to_grant: got %b expected 100", grant_o); end
        tick();
        checks++; if (s_err_o !== 3'b000) begin errors++; $display("FAIL to_pulse_len: got %b expected 000", s_err_o); end
        checks++; if ({grant_o, m_cyc_o} !== 4'b1000) begin errors++; $display("FAIL to_abort_hold: got %b expected 1000", {grant_o, m_cyc_o}); end
        s_cyc_i = 3'b000; s_stb_i = 3'b000;
        tick();
        checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL to_idle: got %b expected 000", grant_o); end
        s_cyc_i = 3'b111; s_stb_i = 3'b111;
        tick();
        checks++; if (grant_o !== 3'b001) begin errors++; $display("FAIL to_ptr_wrap: got %b expected 001", grant_o); end
    endtask

    task automatic test_ack_on_timeout();
        apply_reset();
        set_req(2, 1'b0, 32'h0000_3004, 32'h0, 3'b000);
        s_cyc_i = 3'b100; s_stb_i = 3'b100;
        tick();
        repeat (TO - 1) tick();
        m_ack_i = 1'b1;
        settle();
        checks++; if (s_ack_o !== 3'b100) begin errors++; $display("FAIL ackto_ack: got %b expected 100", s_ack_o); end
        checks++; if (s_err_o !== 3'b000) begin errors++; $display("FAIL ackto_err: got %b expected 000", s_err_o); end
        tick();
        m_ack_i = 1'b0; s_cyc_i = 3'b000; s_stb_i = 3'b000;
        settle();
        checks++; if ({s_err_o, s_ack_o} !== 6'b000000) begin errors++; $display("FAIL ackto_no_abort: got %b expected 000000", {s_err_o, s_ack_o}); end
        tick();
        checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL ackto_idle: got %b expected 000", grant_o); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_req(1, 1'b1, 32'h0000_5000, 32'hCAFE_0001, 3'b000);
        s_cyc_i = 3'b010; s_stb_i = 3'b010;
        tick();
        settle();
        checks++; if (m_cyc_o !== 1'b1) begin errors++; $display("FAIL rmid_active: got %b expected 1", m_cyc_o); end
        s_cyc_i = 3'b111; s_stb_i = 3'b111; m_ack_i = 1'b1;
        reset = 1'b0;
        settle();
        checks++; if ({m_cyc_o, grant_o} !== 4'b0000) begin errors++; $display("FAIL rmid_abandon: got %b expected 0000", {m_cyc_o, grant_o}); end
        checks++; if (s_ack_o !== 3'b000) begin errors++; $display("FAIL rmid_no_ack: got %b expected 000", s_ack_o); end
        @(posedge clk);
        #1;
        reset = 1'b1; m_ack_i = 1'b0;
        tick();
        checks++; if (grant_o !== 3'b001) begin errors++; $display("FAIL rmid_first: got %b expected 001", grant_o); end
    endtask

    task automatic test_read_data();
        apply_reset();
        set_req(0, 1'b0, 32'h0000_0040, 32'h0, 3'b000);
        s_cyc_i = 3'b001; s_stb_i = 3'b001;
        tick();
        m_dat_i = 32'hA5A5_0001; m_ack_i = 1'b1;
        settle();
        checks++; if (s_dat_o !== 32'hA5A5_0001) begin errors++; $display("FAIL rd_data: got %h expected a5a50001", s_dat_o); end
        checks++; if (s_ack_o !== 3'b001) begin errors++; $display("FAIL rd_ack: got %b expected 001", s_ack_o); end
        checks++; if (m_we_o !== 1'b0) begin errors++; $display("FAIL rd_we: got %b expected 0", m_we_o); end
    endtask

    task automatic test_drop_on_grant();
        apply_reset();
        s_cyc_i = 3'b010; s_stb_i = 3'b010;
        tick();
        s_cyc_i = 3'b000; s_stb_i = 3'b000;
        settle();
        checks++; if ({grant_o, m_cyc_o} !== 4'b0100) begin errors++; $display("FAIL drop_busy: got %b expected 0100", {grant_o, m_cyc_o}); end
        tick();
        checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL drop_idle: got %b expected 000", grant_o); end
    endtask

    typedef enum {P_IDLE, P_BUSY, P_ABORT} phase_e;

    task automatic test_random();
        phase_e        ph = P_IDLE;
        int            owner = 0;
        int unsigned   ptr = 0;
        int unsigned   stalls = 0;
        bit            pulse = 1'b0;
        bit            act [NM];
        bit            done [NM];
        int unsigned   gap [NM];
        logic [AW-1:0] ra [NM];
        logic [DW-1:0] rd [NM];
        bit            rw [NM];
        logic [NM-1:0] cyc, exp_grant, exp_ack, exp_err;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdat;
        logic          exp_cyc;
        bit            ack, err;
        apply_reset();
        for (int unsigned i = 0; i < NM; i++) begin
            act[i] = 1'b0; done[i] = 1'b0; gap[i] = i; ra[i] = '0; rd[i] = '0; rw[i] = 1'b0;
        end
        for (int n = 0; n < 600; n++) begin
            for (int unsigned i = 0; i < NM; i++) begin
                if (done[i]) begin
                    act[i] = 1'b0; done[i] = 1'b0; gap[i] = $urandom_range(0, 2);
                end else if (!act[i]) begin
                    if (gap[i] == 0) begin
                        act[i] = 1'b1; ra[i] = $urandom; rd[i] = $urandom; rw[i] = 1'($urandom_range(0, 1));
                    end else begin
                        gap[i]--;
                    end
                end
                cyc[i] = act[i];
                set_req(i, rw[i], ra[i], rd[i], 3'b000);
            end
            s_cyc_i = cyc; s_stb_i = cyc;
            ack = (ph == P_BUSY) && ($urandom_range(0, 4) < 2);
            err = (ph == P_BUSY) && !ack && ($urandom_range(0, 15) == 0);
            m_ack_i = ack; m_err_i = err; m_dat_i = $urandom;
            settle();
            exp_grant = '0;
            if (ph != P_IDLE) exp_grant[owner] = 1'b1;
            exp_cyc  = (ph == P_BUSY) && cyc[owner];
            exp_addr = (ph == P_BUSY) ? ra[owner] : '0;
            exp_wdat = (ph == P_BUSY) ? rd[owner] : '0;
            exp_ack  = (ph == P_BUSY && ack) ? exp_grant : '0;
            exp_err  = ((ph == P_BUSY && err) || pulse) ? exp_grant : '0;
            checks++; if (grant_o !== exp_grant) begin errors++; $display("FAIL rnd_grant@%0d: got %b expected %b", n, grant_o, exp_grant); end
            checks++; if ({m_cyc_o, m_stb_o} !== {exp_cyc, exp_cyc}) begin errors++; $display("FAIL rnd_cyc_stb@%0d: got %b expected %b", n, {m_cyc_o, m_stb_o}, {exp_cyc, exp_cyc}); end
            checks++; if (m_addr_o !== exp_addr) begin errors++; $display("FAIL rnd_addr@%0d: got %h expected %h", n, m_addr_o, exp_addr); end
            checks++; if (m_dat_o !== exp_wdat) begin errors++; $display("FAIL rnd_wdat@%0d: got %h expected %h", n, m_dat_o, exp_wdat); end
            checks++; if (s_ack_o !== exp_ack) begin errors++; $display("FAIL rnd_ack@%0d: got %b expected %b", n, s_ack_o, exp_ack); end
            checks++; if (s_err_o !== exp_err) begin errors++; $display("FAIL rnd_err@%0d: got %b expected %b", n, s_err_o, exp_err); end
            checks++; if (s_dat_o !== m_dat_i) begin errors++; $display("FAIL rnd_rdat@%0d: got %h expected %h", n, s_dat_o, m_dat_i); end
            for (int unsigned i = 0; i < NM; i++) begin
                if (exp_ack[i] || exp_err[i]) done[i] = 1'b1;
            end
            pulse = 1'b0;
            case (ph)
                P_IDLE: begin
                    if (cyc != '0) begin
                        owner = pick(cyc, ptr); ph = P_BUSY; stalls = 0;
                    end
                end
                P_BUSY: begin
                    if (!cyc[owner]) begin
                        ph = P_IDLE; ptr = (owner + 1) % NM;
                    end else if (!ack && !err) begin
                        stalls++;
                        if (stalls == TO) begin ph = P_ABORT; pulse = 1'b1; end
                    end else begin
                        stalls = 0;
                    end
                end
                default: begin
                    if (!cyc[owner]) begin
                        ph = P_IDLE; ptr = (owner + 1) % NM;
                    end
                end
            endcase
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_round_robin();
        test_burst();
        test_timeout();
        test_ack_on_timeout();
        test_reset_mid();
        test_read_data();
        test_drop_on_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
